prio_enc_stream: RTL and testbench
==================================

// Module: prio_enc_stream
// PURPOSE
//  Parametrised, registered priority encoder with request capture and a stream output.
//  Single-cycle req pulses are latched into a pending vector, encoded one at a time,
//  and presented as W-bit codes on a valid/ready interface.
//  Fixed priority (highest index wins) or round-robin, selected at elaboration.
//  Sits between interrupt/event sources and a downstream dispatcher.
// PARAMETERS
//  N   8  number of request lines; N >= 2
//  RR  0  0 = fixed priority (bit N-1 highest), 1 = round-robin
//  W = $clog2(N) is a derived localparam, not overridable
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  rst_n      in   1  synchronous reset, active low
//  en         in   1  request capture enable
//  req        in   N  request pulses/levels, sampled every cycle when en=1
//  out_ready  in   1  downstream accepts out_code this cycle
//  out_valid  out  1  out_code holds a valid encoded request
//  out_code   out  W  index of the granted request
//  pending    out  N  captured, not-yet-granted requests (registered)
//  idle       out  1  pending==0 && !out_valid (combinational from registers)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge)
//   - pending=0, out_valid=0, out_code=0, RR pointer ptr=N-1.
//   - Applies mid-operation: in-flight code and all pending bits are discarded.
//   - idle=1 the cycle after reset.
//  Capture
//   - set = en ? req : 0.
//   - pending_next = (pending & ~clr) | set; clr = one-hot of grant, else 0.
//   - Set wins over clear on the same bit in the same cycle.
//   - en=0 blocks new capture only; pending still drains.
//  Load condition
//   - load = (!out_valid || out_ready) && (pending != 0).
//   - Selection uses registered pending only, never same-cycle req.
//   - Latency: req at edge t -> pending at t+1 -> out_valid at t+2.
//  Grant on load
//   - out_code <= selected index; out_valid <= 1; selected bit cleared from pending.
//   - Accept with nothing pending: out_valid <= 0, out_code holds its last value.
//   - Sustains one code per cycle when out_ready=1 continuously.
//  Backpressure
//   - While out_valid && !out_ready: out_code and out_valid held stable.
//   - No grant occurs; pending keeps accumulating.
//  Fixed mode (RR=0): highest set index in pending wins.
//  Round-robin (RR=1)
//   - Search ptr, ptr-1, ..., 0, N-1, ... (descending with wrap); first set bit wins.
//   - After a grant of k: ptr <= (k==0) ? N-1 : k-1.
//   - ptr changes only on a grant.
//  Width
//   - N not a power of two: codes >= N are never produced.
//   - All index arithmetic is modulo N.
//  No X is ever driven on any output.
// TESTING
//  1. rst_n=0 for 2 cycles with req=all ones, en=1
//     -> out_valid=0, pending=0, out_code=0, idle=1.
//  2. RR=0, N=8: req=8'b0010_0100 for 1 cycle, out_ready=1
//     -> out_valid at t+2 with code 5, then code 2 at t+3, then out_valid=0, idle=1.
//  3. RR=0: code 5 valid with out_ready=0 for 4 cycles, req bit 7 arrives meanwhile
//     -> code 5 held stable; after ready: 5 accepted, then 7.
//  4. RR=1, N=8: req=8'hFF held, out_ready=1
//     -> codes 7,6,5,4,3,2,1,0,7 on consecutive cycles.
//  5. Bit 3 re-requested in its grant cycle
//     -> pending[3] stays 1; code 3 is emitted again later.
//  6. N=5: en=0 with req=5'b10000 -> ignored, idle stays 1;
//     en=1, same req -> out_code=3'd4.

Source files
------------

// File: rtl/prio_enc_stream.sv
// Registered priority encoder: latches request pulses into a pending vector and
// streams one granted index per cycle over a valid/ready output.
module prio_enc_stream #(
    parameter int N  = 8,
    parameter int RR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_code,
    output logic [N-1:0]         pending,
    output logic                 idle
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_code_q, out_code_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic         found;
    logic         load;
    int           sel_idx;
    int           ptr_int;
    int           idx;

    // Search over registered pending only. In round-robin mode the loop runs from
    // the lowest-priority offset to the highest, so the last hit (ptr itself) wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = 0;
        ptr_int = int'(ptr_q);
        idx     = 0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) begin
                    found   = 1'b1;
                    sel_idx = i;
                end
            end
        end else begin
            for (int d = N - 1; d >= 0; d--) begin
                idx = (ptr_int >= d) ? (ptr_int - d) : (ptr_int + N - d);
                if (pending_q[idx]) begin
                    found   = 1'b1;
                    sel_idx = idx;
                end
            end
        end
    end

    // Output handshake: a code transfers on a cycle where out_valid && out_ready.
    // While out_valid && !out_ready, out_code/out_valid hold and no grant is made.
    assign load = (!out_valid_q || out_ready) && found;

    always_comb begin
        set_vec = en ? req : '0;
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (load && (i == sel_idx)) begin
                clr_vec[i] = 1'b1;
            end
        end
        pending_d   = (pending_q & ~clr_vec) | set_vec;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_code_d  = W'(sel_idx);
            ptr_d       = (sel_idx == 0) ? PTR_RST : W'(sel_idx - 1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            ptr_q       <= PTR_RST;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign pending   = pending_q;
    assign idle      = ~(|pending_q) & ~out_valid_q;

endmodule

// File: tb/tb_prio_enc_stream.sv
// Directed bench for prio_enc_stream: fixed N=8, round-robin N=8 and fixed N=5
// instances driven side by side from one linear sequence of steps.
module tb_prio_enc_stream;
    logic clk = 1'b0;
    logic rst_n;

    logic       en0, rdy0, v0, idle0;
    logic [7:0] req0, pend0;
    logic [2:0] code0;
    logic       en1, rdy1, v1, idle1;
    logic [7:0] req1, pend1;
    logic [2:0] code1;
    logic       en2, rdy2, v2, idle2;
    logic [4:0] req2, pend2;
    logic [2:0] code2;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    prio_enc_stream #(.N(8), .RR(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .en(en0), .req(req0), .out_ready(rdy0),
        .out_valid(v0), .out_code(code0), .pending(pend0), .idle(idle0));
    prio_enc_stream #(.N(8), .RR(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .en(en1), .req(req1), .out_ready(rdy1),
        .out_valid(v1), .out_code(code1), .pending(pend1), .idle(idle1));
    prio_enc_stream #(.N(5), .RR(0)) u_fix5 (
        .clk(clk), .rst_n(rst_n), .en(en2), .req(req2), .out_ready(rdy2),
        .out_valid(v2), .out_code(code2), .pending(pend2), .idle(idle2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with all requests asserted
        rst_n = 1'b0;
        en0 = 1'b1; req0 = 8'hFF; rdy0 = 1'b1;
        en1 = 1'b1; req1 = 8'hFF; rdy1 = 1'b1;
        en2 = 1'b1; req2 = 5'h1F; rdy2 = 1'b1;
        tick();
        tick();
        chk("rst_valid0", v0, 0);   chk("rst_pend0", pend0, 0);
        chk("rst_code0", code0, 0); chk("rst_idle0", idle0, 1);
        chk("rst_valid1", v1, 0);   chk("rst_pend1", pend1, 0);
        chk("rst_valid2", v2, 0);   chk("rst_code2", code2, 0);
        rst_n = 1'b1;
        req0 = 8'h00; req1 = 8'h00; req2 = 5'h00;
        tick();
        chk("post_rst_idle0", idle0, 1);
        chk("post_rst_idle1", idle1, 1);
        chk("post_rst_idle2", idle2, 1);

        // Fixed: two bits in one pulse, drained highest first
        req0 = 8'b0010_0100;
        tick();
        req0 = 8'h00;
        chk("t2_pend", pend0, 8'h24); chk("t2_nv", v0, 0);
        tick();
        chk("t2_v5", v0, 1); chk("t2_c5", code0, 5); chk("t2_pend2", pend0, 8'h04);
        tick();
        chk("t2_v2", v0, 1); chk("t2_c2", code0, 2); chk("t2_pend0", pend0, 8'h00);
        tick();
        chk("t2_drain_v", v0, 0); chk("t2_hold_code", code0, 2); chk("t2_idle", idle0, 1);

        // Fixed: backpressure holds code 5 while bit 7 arrives
        rdy0 = 1'b0;
        req0 = 8'h20;
        tick();
        req0 = 8'h00;
        tick();
        chk("t3_v5", v0, 1); chk("t3_c5", code0, 5);
        req0 = 8'h80;
        for (int i = 0; i < 4; i++) begin
            tick();
            req0 = 8'h00;
            chk("t3_hold_v", v0, 1); chk("t3_hold_c", code0, 5);
            chk("t3_pend7", pend0, 8'h80);
        end
        rdy0 = 1'b1;
        tick();
        chk("t3_v7", v0, 1); chk("t3_c7", code0, 7); chk("t3_pend_empty", pend0, 0);
        tick();
        chk("t3_done", v0, 0); chk("t3_idle", idle0, 1);

        // Fixed: bit 3 re-requested in the cycle it is granted
        req0 = 8'h08;
        tick();
        tick();
        req0 = 8'h00;
        chk("t5_c3", code0, 3); chk("t5_v", v0, 1); chk("t5_pend3_kept", pend0, 8'h08);
        tick();
        chk("t5_c3_again", code0, 3); chk("t5_v_again", v0, 1); chk("t5_pend_clr", pend0, 0);
        tick();
        chk("t5_idle", idle0, 1);

        // Round-robin: all requests held, descending sequence with wrap
        for (int k = 7; k >= 0; k--) exp_q.push_back(3'(k));
        exp_q.push_back(3'd7);
        req1 = 8'hFF;
        tick();
        chk("t4_nv", v1, 0); chk("t4_pend", pend1, 8'hFF);
        while (exp_q.size() > 0) begin
            tick();
            chk("t4_v", v1, 1);
            chk("t4_code", code1, exp_q.pop_front());
        end

        // Mid-operation reset discards in-flight code and pending bits
        rst_n = 1'b0;
        req1 = 8'h00;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_v", v1, 0); chk("mid_rst_pend", pend1, 0);
        chk("mid_rst_code", code1, 0); chk("mid_rst_idle", idle1, 1);

        // Round-robin pointer: after granting 2, bit 0 beats bit 7
        req1 = 8'h04;
        tick();
        req1 = 8'h00;
        tick();
        chk("rr_c2", code1, 2);
        req1 = 8'h81;
        tick();
        req1 = 8'h00;
        chk("rr_pend81", pend1, 8'h81); chk("rr_gap_v", v1, 0);
        tick();
        chk("rr_c0", code1, 0); chk("rr_v0", v1, 1);
        tick();
        chk("rr_c7", code1, 7); chk("rr_v7", v1, 1);
        tick();
        chk("rr_idle", idle1, 1);

        // N=5: capture gated by en, then top index encoded
        en2 = 1'b0;
        req2 = 5'b10000;
        tick();
        tick();
        chk("n5_gated_idle", idle2, 1); chk("n5_gated_pend", pend2, 0);
        en2 = 1'b1;
        tick();
        req2 = 5'h00;
        chk("n5_pend", pend2, 5'b10000);
        tick();
        chk("n5_v", v2, 1); chk("n5_c4", code2, 4);
        tick();
        chk("n5_done", v2, 0); chk("n5_idle", idle2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
